mips_run_monitor: RTL and testbench

MIPS_RUN_MONITOR -- requirements
Module: mips_run_monitor

---
 rtl/mips_run_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_mips_run_monitor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mips_run_monitor
// Purpose  : Resets a processor under test, traces distinct ALU results while
//            it runs, ends the run on a stable result or a cycle timeout, then
//            lets the trace be read back oldest-first.
//            Optional feature macro: MIPS_RUN_MONITOR_SENTINEL_EN
// Revision : 1.0
// ============================================================================
module mips_run_monitor #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int RESET_CYCLES  = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int TIMEOUT       = 1024
`ifdef MIPS_RUN_MONITOR_SENTINEL_EN
  ,
  parameter logic [DATA_WIDTH-1:0] SENTINEL = DATA_WIDTH'(32'hFFFF_FFFF)
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   result_in,
  output logic                    cpu_reset,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             cycle_count,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int RW = $clog2(RESET_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RESET_DUT = 2'd1,
    S_RUN       = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]          stable_q, stable_d;
  logic [DATA_WIDTH-1:0]  prev_q, prev_d;
  logic [31:0]            cycle_count_q, cycle_count_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic                   mem_we;

  logic                   first_cycle;
  logic                   changed;
  logic                   capture;
  logic                   sentinel_hit;
  logic                   end_stable;
  logic                   end_timeout;
  logic [SW-1:0]          stable_next;
  logic [31:0]            cycle_next;

`ifdef MIPS_RUN_MONITOR_SENTINEL_EN
  assign sentinel_hit = (result_in == SENTINEL);
`else
  assign sentinel_hit = 1'b0;
`endif

  // cycle_count is cleared by start and only advances in RUN, so zero marks the first RUN cycle
  assign first_cycle = (cycle_count_q == 32'd0);
  assign changed     = (result_in != prev_q);
  assign capture     = first_cycle || changed || sentinel_hit;
  assign stable_next = (first_cycle || changed) ? '0 : stable_q + SW'(1);
  assign cycle_next  = cycle_count_q + 32'd1;
  assign end_stable  = (stable_next == SW'(STABLE_CYCLES - 1)) || sentinel_hit;
  assign end_timeout = (cycle_next == 32'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    stable_d      = stable_q;
    prev_d        = prev_q;
    cycle_count_d = cycle_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    mem_we        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RESET_DUT;
          rst_cnt_d     = '0;
          stable_d      = '0;
          cycle_count_d = '0;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          count_d       = '0;
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          overflow_d    = 1'b0;
        end else if ((state_q == S_DONE) && rd_en && (count_q != '0)) begin
          rd_data_d  = mem_q[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          count_d    = count_q - CW'(1);
        end
      end

      S_RESET_DUT: begin
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      S_RUN: begin
        prev_d        = result_in;
        cycle_count_d = cycle_next;
        stable_d      = stable_next;
        if (capture) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          // A full buffer drops its oldest entry so the newest history survives
          if (count_q == CW'(DEPTH)) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        if (end_stable) begin
          done_d = 1'b1;
        end
        if (end_timeout) begin
          timeout_d = 1'b1;
        end
        if (end_stable || end_timeout) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      stable_q      <= '0;
      prev_q        <= '0;
      cycle_count_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stable_q      <= stable_d;
      prev_q        <= prev_d;
      cycle_count_q <= cycle_count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Trace storage carries no reset; entries are only visible through count
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[wr_ptr_q] <= result_in;
    end
  end

  assign cpu_reset   = (state_q == S_IDLE) || (state_q == S_RESET_DUT);
  assign busy        = (state_q == S_RESET_DUT) || (state_q == S_RUN);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign count       = count_q;
  assign cycle_count = cycle_count_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_run_monitor
// Purpose  : Self-checking bench for mips_run_monitor (directed + random runs
//            against a trace-level reference model).
// Revision : 1.0
// ============================================================================
module tb_mips_run_monitor;

  localparam int DW            = 32;
  localparam int DEPTH         = 4;
  localparam int RESET_CYCLES  = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int TIMEOUT       = 20;
  localparam int SEQ_LEN       = 32;
`ifdef MIPS_RUN_MONITOR_SENTINEL_EN
  localparam bit SENT_EN = 1'b1;
`else
  localparam bit SENT_EN = 1'b0;
`endif
  localparam logic [31:0] SENT_VAL = 32'hFFFF_FFFF;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [DW-1:0]          result_in;
  logic                   cpu_reset;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic                   overflow;
  logic [$clog2(DEPTH):0] count;
  logic [31:0]            cycle_count;
  logic                   rd_en;
  logic [DW-1:0]          rd_data;
  logic                   rd_valid;

  int errors = 0;
  int checks = 0;

  logic [31:0] seq [SEQ_LEN];
  logic [31:0] exp_q [$];
  int          exp_cycles;
  bit          exp_done;
  bit          exp_to;
  bit          exp_ovf;

  mips_run_monitor #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .RESET_CYCLES  (RESET_CYCLES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .result_in   (result_in),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .overflow    (overflow),
    .count       (count),
    .cycle_count (cycle_count),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trace-level model: a run captures every new value, ends when a value has
  // been seen STABLE_CYCLES times in a row, at TIMEOUT cycles, or on sentinel.
  task automatic model_run();
    logic [31:0] caps [$];
    int          run_len;
    bit          sent;
    bit          is_new;
    caps       = {};
    run_len    = 0;
    exp_done   = 1'b0;
    exp_to     = 1'b0;
    exp_cycles = SEQ_LEN;
    for (int i = 0; i < SEQ_LEN; i++) begin
      sent   = SENT_EN && (seq[i] == SENT_VAL);
      is_new = 1'b1;
      if (i > 0) is_new = (seq[i] != seq[i-1]);
      run_len = is_new ? 1 : run_len + 1;
      if (is_new || sent) caps.push_back(seq[i]);
      exp_done = (run_len >= STABLE_CYCLES) || sent;
      exp_to   = (i + 1 == TIMEOUT);
      if (exp_done || exp_to) begin
        exp_cycles = i + 1;
        break;
      end
    end
    exp_ovf = (caps.size() > DEPTH);
    while (caps.size() > DEPTH) void'(caps.pop_front());
    exp_q = caps;
  endtask

  task automatic start_dut(input string name);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && cpu_reset && n < 20) begin
      n++;
      tick();
    end
    check($sformatf("%s.reset_cycles", name), n, RESET_CYCLES);
    check($sformatf("%s.run_entry{busy,cpu_reset}", name), {busy, cpu_reset}, 2'b10);
  endtask

  task automatic feed(input string name, input int max_k, output int k);
    k = 0;
    while (busy && k < max_k) begin
      result_in = seq[k];
      start     = (k == 2);
      rd_en     = (k == 1);
      tick();
      k++;
      if (k == 2) check($sformatf("%s.rd_en_ignored_in_run", name), rd_valid, 1'b0);
    end
    start = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    int k;
    model_run();
    start_dut(name);
    feed(name, SEQ_LEN, k);
    check($sformatf("%s.run_length", name), k, exp_cycles);
    check($sformatf("%s.busy_after", name), busy, 1'b0);
    check($sformatf("%s.cycle_count", name), cycle_count, exp_cycles);
    check($sformatf("%s.done", name), done, exp_done);
    check($sformatf("%s.timeout", name), timeout, exp_to);
    check($sformatf("%s.overflow", name), overflow, exp_ovf);
    check($sformatf("%s.count", name), count, exp_q.size());
  endtask

  task automatic pop_all(input string name);
    int sz;
    sz = exp_q.size();
    for (int i = 0; i < sz; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check($sformatf("%s.pop%0d.rd_valid", name, i), rd_valid, 1'b1);
      check($sformatf("%s.pop%0d.rd_data", name, i), rd_data, exp_q[i]);
      check($sformatf("%s.pop%0d.count", name, i), count, sz - 1 - i);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check($sformatf("%s.empty_pop.rd_valid", name), rd_valid, 1'b0);
    check($sformatf("%s.empty_pop.count", name), count, 0);
    check($sformatf("%s.hold.done", name), done, exp_done);
    check($sformatf("%s.hold.timeout", name), timeout, exp_to);
    check($sformatf("%s.hold.cycle_count", name), cycle_count, exp_cycles);
    check($sformatf("%s.hold.cpu_reset", name), cpu_reset, 1'b0);
  endtask

  task automatic gen_random();
    int          i;
    int          h;
    logic [31:0] v;
    i = 0;
    while (i < SEQ_LEN) begin
      v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : ($urandom & 32'h7FFF_FFFF);
      h = $urandom_range(1, 9);
      for (int j = 0; j < h && i < SEQ_LEN; j++) begin
        seq[i] = v;
        i++;
      end
    end
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    start     = 1'b0;
    rd_en     = 1'b0;
    result_in = '0;
    tick();
    tick();
    check("rst.cpu_reset", cpu_reset, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.flags{done,timeout,overflow}", {done, timeout, overflow}, 3'b000);
    check("rst.count", count, 0);
    check("rst.cycle_count", cycle_count, 0);
    check("rst.rd", {rd_valid, rd_data}, 33'd0);
    reset = 1'b0;
    tick();
    tick();
    check("idle.cpu_reset", cpu_reset, 1'b1);
    check("idle.busy", busy, 1'b0);

    // 1,2,3 then hold 3
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = (i < 3) ? i + 1 : 3;
    run_to_done("stable");
    check("stable.done_const", done, 1'b1);
    check("stable.count_const", count, 3);
    pop_all("stable");

    // 1..10 then hold 10: keeps the last four
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = (i < 10) ? i + 1 : 10;
    run_to_done("wrap");
    check("wrap.overflow_const", overflow, 1'b1);
    check("wrap.count_const", count, 4);
    check("wrap.model_head", exp_q[0], 32'd7);
    pop_all("wrap");
    check("wrap.last_pop", rd_data, 32'd10);

    // toggling never settles
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = (i % 2 == 0) ? 32'h5 : 32'hA;
    run_to_done("toggle");
    check("toggle.flags{done,timeout}", {done, timeout}, 2'b01);
    check("toggle.cycle_count_const", cycle_count, 32'd20);
    pop_all("toggle");

    for (int r = 0; r < 8; r++) begin
      gen_random();
      run_to_done($sformatf("rand%0d", r));
      pop_all($sformatf("rand%0d", r));
    end

`ifdef MIPS_RUN_MONITOR_SENTINEL_EN
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = (i == 0) ? 32'd5 : ((i == 1) ? SENT_VAL : 32'd7);
    run_to_done("sentinel");
    check("sentinel.done_const", done, 1'b1);
    check("sentinel.count_const", count, 2);
    pop_all("sentinel");
    check("sentinel.last_pop", rd_data, SENT_VAL);
`endif

    // abort a run with reset
    for (int i = 0; i < SEQ_LEN; i++) seq[i] = i + 100;
    start_dut("abort");
    feed("abort", 5, k);
    check("abort.mid_run_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.busy", busy, 1'b0);
    check("abort.cpu_reset", cpu_reset, 1'b1);
    check("abort.count", count, 0);
    check("abort.cycle_count", cycle_count, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("abort.rd_valid", rd_valid, 1'b0);
    tick();
    check("abort.idle_cpu_reset", cpu_reset, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
